// File: rtl/ofifo.sv
// rtl/ofifo.sv - per-column output FIFO that realigns skewed MAC column results into full rows
module ofifo #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int depth   = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [psum_bw*col-1:0] in,
  input  logic [col-1:0]         wr,
  input  logic                   rd,
  output logic [psum_bw*col-1:0] out,
  output logic                   o_full,
  output logic                   o_ready,
  output logic                   o_valid,
  output logic                   o_overflow
);

  localparam int aw = $clog2(depth);
  localparam logic [aw:0] ptr_one = {{aw{1'b0}}, 1'b1};

  logic [col-1:0] lane_full;
  logic [col-1:0] lane_empty;
  logic [col-1:0] wr_acc;
  logic           rd_acc;

  // A row is only available once every lane holds at least one entry.
  assign o_valid = ~|lane_empty;
  assign o_full  = |lane_full;
  assign o_ready = ~o_full;
  assign rd_acc  = rd & o_valid;

  for (genvar c = 0; c < col; c++) begin : g_lane
    logic [psum_bw-1:0] mem [depth];
    logic [aw:0]        wptr;
    logic [aw:0]        rptr;
    logic [psum_bw-1:0] q;

    // The wrap bit distinguishes full from empty when the low pointer bits match.
    assign lane_empty[c] = (wptr == rptr);
    assign lane_full[c]  = (wptr[aw-1:0] == rptr[aw-1:0]) && (wptr[aw] != rptr[aw]);
    // A pop in the same cycle frees a slot, so a full lane can still take a write.
    assign wr_acc[c]     = wr[c] & (~lane_full[c] | rd_acc);
    assign out[psum_bw*c +: psum_bw] = q;

    // Lane storage write; contents are deliberately not cleared by reset.
    always_ff @(posedge clk) begin
      if (!reset && wr_acc[c]) begin
        mem[wptr[aw-1:0]] <= in[psum_bw*c +: psum_bw];
      end
    end

    // Pointer advance; all read pointers move together on an accepted row pop.
    always_ff @(posedge clk) begin
      if (reset) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (wr_acc[c]) wptr <= wptr + ptr_one;
        if (rd_acc)    rptr <= rptr + ptr_one;
      end
    end

    // Registered popped value, held until the next accepted read.
    always_ff @(posedge clk) begin
      if (reset) begin
        q <= '0;
      end else if (rd_acc) begin
        q <= mem[rptr[aw-1:0]];
      end
    end
  end

  // Sticky record of any dropped write; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_overflow <= 1'b0;
    end else if (|(wr & ~wr_acc)) begin
      o_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ofifo.sv
// tb/tb_ofifo.sv - directed self-checking bench for ofifo
module tb_ofifo;

  logic         clk;
  logic         reset;
  logic [127:0] din;
  logic [7:0]   wr;
  logic         rd;
  logic [127:0] dout;
  logic         o_full;
  logic         o_ready;
  logic         o_valid;
  logic         o_overflow;

  int n_vec;
  int n_err;
  logic [127:0] q[$];
  logic [127:0] exp_row;
  logic [127:0] skew_row;
  logic [127:0] held;

  ofifo #(.col(8), .psum_bw(16), .depth(64)) dut (
    .clk        (clk),
    .reset      (reset),
    .in         (din),
    .wr         (wr),
    .rd         (rd),
    .out        (dout),
    .o_full     (o_full),
    .o_ready    (o_ready),
    .o_valid    (o_valid),
    .o_overflow (o_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] mkrow(input int r);
    logic [127:0] v;
    for (int c = 0; c < 8; c++) v[16*c +: 16] = 16'(32'h1000 + r * 16 + c);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [7:0] w, input logic [127:0] d);
    rd  = r;
    wr  = w;
    din = d;
    @(posedge clk);
    #1;
    rd  = 1'b0;
    wr  = 8'h00;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    rd    = 1'b1;
    wr    = 8'hFF;
    din   = {4{32'hDEADBEEF}};
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset_out", dout, 128'h0);
    chk("reset_valid", {127'h0, o_valid}, 128'h0);
    chk("reset_full", {127'h0, o_full}, 128'h0);
    chk("reset_ready", {127'h0, o_ready}, 128'h1);
    chk("reset_ovf", {127'h0, o_overflow}, 128'h0);
    reset = 1'b0;
    rd    = 1'b0;
    wr    = 8'h00;

    // Skewed fill: lane c gets its k-th write value 0x0100 + c + 0x10*k
    for (int t = 0; t < 8; t++) begin
      skew_row = '0;
      for (int c = 0; c <= t; c++) skew_row[16*c +: 16] = 16'(32'h0100 + c + 16 * (t - c));
      drive(1'b0, 8'((16'h1 << (t + 1)) - 1), skew_row);
      chk($sformatf("skew_valid_%0d", t), {127'h0, o_valid}, (t == 7) ? 128'h1 : 128'h0);
    end
    drive(1'b1, 8'h00, '0);
    chk("skew_first_row", dout, 128'h0107_0106_0105_0104_0103_0102_0101_0100);
    chk("skew_valid_after_pop", {127'h0, o_valid}, 128'h0);

    // Fill to depth
    reset = 1'b1;
    drive(1'b0, 8'h00, '0);
    reset = 1'b0;
    for (int r = 0; r < 64; r++) begin
      drive(1'b0, 8'hFF, mkrow(r));
      if (r == 62) chk("fill_not_full_63", {127'h0, o_full}, 128'h0);
    end
    chk("fill_full", {127'h0, o_full}, 128'h1);
    chk("fill_ready", {127'h0, o_ready}, 128'h0);
    chk("fill_ovf_clear", {127'h0, o_overflow}, 128'h0);

    // Full with simultaneous read and write of row 100
    drive(1'b1, 8'hFF, mkrow(100));
    chk("rw_full_out", dout, mkrow(0));
    chk("rw_full_stays", {127'h0, o_full}, 128'h1);
    chk("rw_full_no_ovf", {127'h0, o_overflow}, 128'h0);

    // Write with no read at full is dropped
    drive(1'b0, 8'hFF, mkrow(200));
    chk("ovf_set", {127'h0, o_overflow}, 128'h1);
    chk("ovf_still_full", {127'h0, o_full}, 128'h1);

    // Drain: rows 1..63 then row 100
    for (int r = 1; r <= 64; r++) begin
      drive(1'b1, 8'h00, '0);
      chk($sformatf("drain_%0d", r), dout, (r == 64) ? mkrow(100) : mkrow(r));
    end
    chk("drain_empty", {127'h0, o_valid}, 128'h0);
    chk("drain_not_full", {127'h0, o_full}, 128'h0);

    // Empty read: output held, nothing queued
    held = mkrow(100);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'h00, '0);
      chk($sformatf("empty_rd_out_%0d", i), dout, held);
      chk($sformatf("empty_rd_valid_%0d", i), {127'h0, o_valid}, 128'h0);
    end
    drive(1'b0, 8'hFF, mkrow(7));
    chk("single_valid", {127'h0, o_valid}, 128'h1);
    drive(1'b1, 8'h00, '0);
    chk("single_row", dout, mkrow(7));
    chk("single_empty", {127'h0, o_valid}, 128'h0);

    // Pointer wrap with continuous read+write after 4-row prefill
    reset = 1'b1;
    drive(1'b0, 8'h00, '0);
    reset = 1'b0;
    chk("wrap_reset_out", dout, 128'h0);
    chk("wrap_reset_ovf", {127'h0, o_overflow}, 128'h0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 8'hFF, mkrow(i));
      q.push_back(mkrow(i));
    end
    for (int i = 0; i < 200; i++) begin
      exp_row = q.pop_front();
      q.push_back(mkrow(4 + i));
      drive(1'b1, 8'hFF, mkrow(4 + i));
      chk($sformatf("wrap_%0d", i), dout, exp_row);
    end
    chk("wrap_valid", {127'h0, o_valid}, 128'h1);
    chk("wrap_no_ovf", {127'h0, o_overflow}, 128'h0);

    // Mid-operation reset with 10 rows queued
    for (int i = 0; i < 6; i++) drive(1'b0, 8'hFF, mkrow(300 + i));
    chk("pre_reset_valid", {127'h0, o_valid}, 128'h1);
    reset = 1'b1;
    drive(1'b1, 8'hFF, mkrow(400));
    reset = 1'b0;
    chk("mid_reset_valid", {127'h0, o_valid}, 128'h0);
    chk("mid_reset_out", dout, 128'h0);
    chk("mid_reset_full", {127'h0, o_full}, 128'h0);
    chk("mid_reset_ready", {127'h0, o_ready}, 128'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
